alu_issue_stage: RTL and testbench

- Decode/issue pipeline stage that produces the ALU's interface: alu_op, oper1 and oper2.
- Takes a fetched RV32I instruction, its PC and the register-file read data.
- Decodes ALU-class instructions into ALU_* operation codes (define/consts.v) and selected operands, registered behind a valid/ready handshake.
- Sits between fetch/regfile read and the execute stage containing the ALU.

---
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_issue_stage.sv | 217 +++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction/regfile handshake and the registered
// ALU-facing entry handed to the execute stage.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_op;
    logic [XLEN-1:0] out_oper1;
    logic [XLEN-1:0] out_oper2;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic            out_branch;
    logic            out_illegal;

    // Driver side: feeds instructions and consumes the issued entry.
    modport master (
        output flush, in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, out_alu_op, out_oper1, out_oper2,
               out_rd, out_wen, out_branch, out_illegal
    );

    // Issue stage side.
    modport slave (
        input  flush, in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, out_alu_op, out_oper1, out_oper2,
               out_rd, out_wen, out_branch, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I ALU-class instructions (OP, OP-IMM, LUI,
// AUIPC, BRANCH) into an ALU op code and operands, held in a single-entry
// valid/ready pipeline register in front of the execute stage.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SL   = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SR   = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SEQ  = 4'd8;
    localparam logic [3:0] ALU_SNE  = 4'd9;
    localparam logic [3:0] ALU_SUB  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_SLT  = 4'd12;
    localparam logic [3:0] ALU_SGE  = 4'd13;
    localparam logic [3:0] ALU_SLTU = 4'd14;
    localparam logic [3:0] ALU_SGEU = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;
    logic signed [XLEN-1:0] imm_i;
    logic signed [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign opcode   = bus.in_inst[6:0];
    assign funct3   = bus.in_inst[14:12];
    assign funct7   = bus.in_inst[31:25];
    assign rd_field = bus.in_inst[11:7];
    assign imm_i    = XLEN'($signed(bus.in_inst[31:20]));
    assign imm_u    = XLEN'($signed({bus.in_inst[31:12], 12'b0}));
    assign shamt    = XLEN'(bus.in_inst[24:20]);

    logic [3:0]      dec_op_p0;
    logic [XLEN-1:0] dec_oper1_p0;
    logic [XLEN-1:0] dec_oper2_p0;
    logic [4:0]      dec_rd_p0;
    logic            dec_wen_p0;
    logic            dec_branch_p0;
    logic            dec_illegal_p0;

    logic            vld_p1;
    logic [3:0]      alu_op_p1;
    logic [XLEN-1:0] oper1_p1;
    logic [XLEN-1:0] oper2_p1;
    logic [4:0]      rd_p1;
    logic            wen_p1;
    logic            branch_p1;
    logic            illegal_p1;

    logic load;

    // Accept whenever the slot is empty or being drained this cycle.
    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

    // Decode the incoming instruction into op code, operands and write-back info.
    always_comb begin
        logic ill;
        ill            = 1'b0;
        dec_op_p0      = ALU_ADD;
        dec_oper1_p0   = '0;
        dec_oper2_p0   = '0;
        dec_rd_p0      = '0;
        dec_wen_p0     = 1'b0;
        dec_branch_p0  = 1'b0;
        dec_illegal_p0 = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_oper1_p0 = bus.rs1_data;
                dec_oper2_p0 = bus.rs2_data;
                dec_rd_p0    = rd_field;
                dec_wen_p0   = 1'b1;
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO)     dec_op_p0 = ALU_ADD;
                        else if (funct7 == F7_ALT) dec_op_p0 = ALU_SUB;
                        else                       ill = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO)     dec_op_p0 = ALU_SR;
                        else if (funct7 == F7_ALT) dec_op_p0 = ALU_SRA;
                        else                       ill = 1'b1;
                    end
                    default: begin
                        ill = (funct7 != F7_ZERO);
                        case (funct3)
                            3'b001:  dec_op_p0 = ALU_SL;
                            3'b010:  dec_op_p0 = ALU_SLT;
                            3'b011:  dec_op_p0 = ALU_SLTU;
                            3'b100:  dec_op_p0 = ALU_XOR;
                            3'b110:  dec_op_p0 = ALU_OR;
                            default: dec_op_p0 = ALU_AND;
                        endcase
                    end
                endcase
            end
            OPC_OP_IMM: begin
                dec_oper1_p0 = bus.rs1_data;
                dec_oper2_p0 = imm_i;
                dec_rd_p0    = rd_field;
                dec_wen_p0   = 1'b1;
                unique case (funct3)
                    3'b000: dec_op_p0 = ALU_ADD;
                    3'b010: dec_op_p0 = ALU_SLT;
                    3'b011: dec_op_p0 = ALU_SLTU;
                    3'b100: dec_op_p0 = ALU_XOR;
                    3'b110: dec_op_p0 = ALU_OR;
                    3'b111: dec_op_p0 = ALU_AND;
                    3'b001: begin
                        dec_op_p0    = ALU_SL;
                        dec_oper2_p0 = shamt;
                        ill          = (funct7 != F7_ZERO);
                    end
                    default: begin
                        // inst[30] picks arithmetic vs logical; every other funct7 bit must be clear.
                        dec_op_p0    = funct7[5] ? ALU_SRA : ALU_SR;
                        dec_oper2_p0 = shamt;
                        ill          = (funct7[6] || (funct7[4:0] != 5'b0));
                    end
                endcase
            end
            OPC_LUI: begin
                dec_oper2_p0 = imm_u;
                dec_rd_p0    = rd_field;
                dec_wen_p0   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_oper1_p0 = bus.in_pc;
                dec_oper2_p0 = imm_u;
                dec_rd_p0    = rd_field;
                dec_wen_p0   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_oper1_p0  = bus.rs1_data;
                dec_oper2_p0  = bus.rs2_data;
                dec_branch_p0 = 1'b1;
                unique case (funct3)
                    3'b000:  dec_op_p0 = ALU_SEQ;
                    3'b001:  dec_op_p0 = ALU_SNE;
                    3'b100:  dec_op_p0 = ALU_SLT;
                    3'b101:  dec_op_p0 = ALU_SGE;
                    3'b110:  dec_op_p0 = ALU_SLTU;
                    3'b111:  dec_op_p0 = ALU_SGEU;
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            dec_op_p0      = ALU_ADD;
            dec_oper1_p0   = '0;
            dec_oper2_p0   = '0;
            dec_rd_p0      = '0;
            dec_wen_p0     = 1'b0;
            dec_branch_p0  = 1'b0;
            dec_illegal_p0 = 1'b1;
        end
        // x0 is never written.
        if (dec_rd_p0 == 5'd0) dec_wen_p0 = 1'b0;
    end

    // ---- p0 -> p1: entry valid tracks load, drain and flush.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) vld_p1 <= 1'b0;
        else if (load)        vld_p1 <= 1'b1;
        else if (bus.out_ready) vld_p1 <= 1'b0;
    end

    // Payload captures the decoded instruction only on load, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_p1  <= ALU_ADD;
            oper1_p1   <= '0;
            oper2_p1   <= '0;
            rd_p1      <= '0;
            wen_p1     <= 1'b0;
            branch_p1  <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (load) begin
            alu_op_p1  <= dec_op_p0;
            oper1_p1   <= dec_oper1_p0;
            oper2_p1   <= dec_oper2_p0;
            rd_p1      <= dec_rd_p0;
            wen_p1     <= dec_wen_p0;
            branch_p1  <= dec_branch_p0;
            illegal_p1 <= dec_illegal_p0;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_alu_op  = alu_op_p1;
    assign bus.out_oper1   = oper1_p1;
    assign bus.out_oper2   = oper2_p1;
    assign bus.out_rd      = rd_p1;
    assign bus.out_wen     = wen_p1;
    assign bus.out_branch  = branch_p1;
    assign bus.out_illegal = illegal_p1;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push their
// hand-computed entry into a queue; a monitor pops and compares on each transfer.
module tb_alu_issue_stage;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_SGE  = 4'd13;
    localparam logic [3:0] ALU_SLTU = 4'd14;
    localparam logic [3:0] ALU_AND  = 4'd7;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [4:0]  rd;
        logic        wen;
        logic        br;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu_issue_if #(.XLEN(32)) bus();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [3:0] op, logic [31:0] o1, logic [31:0] o2,
                                logic [4:0] rd, logic wen, logic br, logic ill);
        exp_t e;
        e.op = op; e.o1 = o1; e.o2 = o2; e.rd = rd; e.wen = wen; e.br = br; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t actual();
        return mk(bus.out_alu_op, bus.out_oper1, bus.out_oper2, bus.out_rd,
                  bus.out_wen, bus.out_branch, bus.out_illegal);
    endfunction

    task automatic check(string name, logic [79:0] act, logic [79:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted output entry is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_entry: got %h expected none", actual());
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (actual() !== e) begin
                    fails++;
                    $display("FAIL entry: got %h expected %h", actual(), e);
                end
            end
        end
    end

    // Drive one instruction starting just after a rising edge; returns once it has loaded.
    task automatic send(logic [31:0] inst, logic [31:0] pc, logic [31:0] r1,
                        logic [31:0] r2, exp_t e);
        bit got;
        got = 0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready && !bus.flush) begin
                sb.push_back(e);
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        exp_t ea, eb, ec;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / idle state.
        @(negedge clk);
        check("reset_valid", 80'(bus.out_valid), 80'(0));
        check("reset_in_ready", 80'(bus.in_ready), 80'(1));
        check("reset_payload", 80'(actual()), 80'(mk(ALU_ADD, 0, 0, 0, 0, 0, 0)));
        @(posedge clk); #1;

        // Back-to-back stream with out_ready high.
        send(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(ALU_SUB, 32'd10, 32'd3, 5'd3, 1, 0, 0));
        send(32'hFFF00293, 32'h0, 32'd0, 32'd0, mk(ALU_ADD, 32'd0, 32'hFFFFFFFF, 5'd5, 1, 0, 0));
        send(32'h4043D313, 32'h0, 32'h80000000, 32'd0, mk(ALU_SRA, 32'h80000000, 32'd4, 5'd6, 1, 0, 0));
        send(32'h0020D063, 32'h0, 32'hFFFFFFFF, 32'd1, mk(ALU_SGE, 32'hFFFFFFFF, 32'd1, 5'd0, 0, 1, 0));
        send(32'h0020A063, 32'h0, 32'hFFFFFFFF, 32'd1, mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 0, 0, 1));
        send(32'h00208033, 32'h0, 32'd7, 32'd8, mk(ALU_ADD, 32'd7, 32'd8, 5'd0, 0, 0, 0));
        send(32'hABCDE537, 32'h0, 32'd5, 32'd6, mk(ALU_ADD, 32'd0, 32'hABCDE000, 5'd10, 1, 0, 0));
        send(32'h02311093, 32'h0, 32'd5, 32'd6, mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 0, 0, 1));
        send(32'hFFFFFFFF, 32'h0, 32'd5, 32'd6, mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 0, 0, 1));
        send(32'h12345097, 32'h100, 32'd0, 32'd0, mk(ALU_ADD, 32'h100, 32'h12345000, 5'd1, 1, 0, 0));
        repeat (2) @(posedge clk); #1;

        // Backpressure: hold XOR while SLTU waits, then release.
        bus.out_ready = 1'b0;
        ea = mk(ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd4, 1, 0, 0);
        eb = mk(ALU_SLTU, 32'd1, 32'd2, 5'd5, 1, 0, 0);
        send(32'h0020C233, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, ea);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0020B2B3;
        bus.rs1_data = 32'd1;
        bus.rs2_data = 32'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_in_ready", 80'(bus.in_ready), 80'(0));
            check("bp_hold", 80'(actual()), 80'(ea));
            check("bp_valid", 80'(bus.out_valid), 80'(1));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 80'(bus.in_ready), 80'(1));
        sb.push_back(eb);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        check("bp_drained", 80'(sb.size()), 80'(0));

        // Flush while holding an entry with a new instruction offered.
        bus.out_ready = 1'b0;
        ec = mk(ALU_AND, 32'd3, 32'd5, 5'd7, 1, 0, 0);
        send(32'h0020F3B3, 32'h0, 32'd3, 32'd5, ec);
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h0020E433;
        bus.flush    = 1'b1;
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("flush_valid", 80'(bus.out_valid), 80'(0));
        check("flush_in_ready", 80'(bus.in_ready), 80'(1));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flush_no_entry", 80'(bus.out_valid), 80'(0));

        // Scoreboard must be drained.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", 80'(sb.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
